// File: rtl/op_select_ctrl_if.sv
// Handshake and mux bus between op_select_ctrl and its requester/consumer.
// The slave modport is the controller's view of the bus.
interface op_select_ctrl_if;
    logic       start;
    logic [2:0] opcode;
    logic [7:0] mux_out;
    logic       ack;
    logic [2:0] sel;
    logic [7:0] result;
    logic       result_valid;
    logic       busy;
    logic [7:0] op_count;

    modport slave (
        input  start, opcode, mux_out, ack,
        output sel, result, result_valid, busy, op_count
    );

    modport master (
        output start, opcode, mux_out, ack,
        input  sel, result, result_valid, busy, op_count
    );
endinterface

// File: rtl/op_select_ctrl.sv
// Drives the select of a downstream 8:1 operation mux, waits SETTLE cycles for the
// mux output to settle, captures it and holds it until the consumer acknowledges.
module op_select_ctrl #(
    parameter int unsigned SETTLE = 2  // legal range 1..15
) (
    input logic               clk,
    input logic               rst_n,
    op_select_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

    localparam logic [3:0] LastCnt = 4'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] result_q, result_d;
    logic       valid_q, valid_d;
    logic [7:0] count_q, count_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sel_q    <= 3'd0;
            result_q <= 8'h00;
            valid_q  <= 1'b0;
            count_q  <= 8'd0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        result_d = result_q;
        valid_d  = valid_q;
        count_d  = count_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sel_d   = bus.opcode;
                    cnt_d   = 4'd0;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                // start, opcode and ack are deliberately not looked at here
                if (cnt_q == LastCnt) begin
                    result_d = bus.mux_out;
                    valid_d  = 1'b1;
                    count_d  = count_q + 8'd1;
                    state_d  = StHold;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StHold: begin
                if (bus.ack) begin
                    valid_d = 1'b0;
                    if (bus.start) begin
                        sel_d   = bus.opcode;
                        cnt_d   = 4'd0;
                        state_d = StSettle;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.sel          = sel_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.op_count     = count_q;
    assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_op_select_ctrl.sv
// Self-checking bench for op_select_ctrl: table-driven vectors on a SETTLE=2 build plus
// directed sequences for latency (SETTLE=1/2/15), op_count wrap and asynchronous reset.
module tb_op_select_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] opcode;
    logic       ack;

    int tests;
    int fails;

    op_select_ctrl_if bus0 ();
    op_select_ctrl_if bus1 ();
    op_select_ctrl_if bus15 ();

    // Shared stimulus; each mux returns 0x70 | sel
    assign bus0.start   = start;
    assign bus0.opcode  = opcode;
    assign bus0.ack     = ack;
    assign bus0.mux_out = {5'b01110, bus0.sel};
    assign bus1.start   = start;
    assign bus1.opcode  = opcode;
    assign bus1.ack     = ack;
    assign bus1.mux_out = {5'b01110, bus1.sel};
    assign bus15.start   = start;
    assign bus15.opcode  = opcode;
    assign bus15.ack     = ack;
    assign bus15.mux_out = {5'b01110, bus15.sel};

    op_select_ctrl #(.SETTLE(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(bus0));
    op_select_ctrl #(.SETTLE(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    op_select_ctrl #(.SETTLE(15)) u_dut15 (.clk(clk), .rst_n(rst_n), .bus(bus15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [2:0]  opcode;
        logic        ack;
        logic [20:0] exp;  // {sel, result, result_valid, busy, op_count}
    } vec_t;

    vec_t vecs[13];

    function automatic logic [20:0] snap0();
        return {bus0.sel, bus0.result, bus0.result_valid, bus0.busy, bus0.op_count};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one op on the shared inputs and wait (bounded) for bus0 to capture it.
    task automatic run_op(input logic [2:0] op, output bit ok);
        start  = 1'b1;
        opcode = op;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(posedge clk); #1;
            if (bus0.result_valid) ok = 1'b1;
        end
        if (!ok) check("op_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack_op();
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
    endtask

    initial begin
        bit ok;
        int lat0, lat1, lat15;
        tests  = 0;
        fails  = 0;
        start  = 1'b0;
        opcode = 3'd0;
        ack    = 1'b0;
        rst_n  = 1'b0;

        vecs[0]  = '{1'b1, 3'd5, 1'b0, {3'd5, 8'h00, 1'b0, 1'b1, 8'd0}};
        vecs[1]  = '{1'b1, 3'd7, 1'b0, {3'd5, 8'h00, 1'b0, 1'b1, 8'd0}};
        vecs[2]  = '{1'b0, 3'd0, 1'b1, {3'd5, 8'h75, 1'b1, 1'b1, 8'd1}};
        vecs[3]  = '{1'b1, 3'd7, 1'b0, {3'd5, 8'h75, 1'b1, 1'b1, 8'd1}};
        vecs[4]  = '{1'b1, 3'd2, 1'b1, {3'd2, 8'h75, 1'b0, 1'b1, 8'd1}};
        vecs[5]  = '{1'b0, 3'd0, 1'b0, {3'd2, 8'h75, 1'b0, 1'b1, 8'd1}};
        vecs[6]  = '{1'b0, 3'd0, 1'b0, {3'd2, 8'h72, 1'b1, 1'b1, 8'd2}};
        vecs[7]  = '{1'b0, 3'd0, 1'b1, {3'd2, 8'h72, 1'b0, 1'b0, 8'd2}};
        vecs[8]  = '{1'b0, 3'd0, 1'b1, {3'd2, 8'h72, 1'b0, 1'b0, 8'd2}};
        vecs[9]  = '{1'b1, 3'd0, 1'b0, {3'd0, 8'h72, 1'b0, 1'b1, 8'd2}};
        vecs[10] = '{1'b0, 3'd0, 1'b0, {3'd0, 8'h72, 1'b0, 1'b1, 8'd2}};
        vecs[11] = '{1'b0, 3'd0, 1'b0, {3'd0, 8'h70, 1'b1, 1'b1, 8'd3}};
        vecs[12] = '{1'b0, 3'd0, 1'b1, {3'd0, 8'h70, 1'b0, 1'b0, 8'd3}};

        #3;
        check("reset_state", {11'd0, snap0()}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency on all three builds from one shared accept
        start  = 1'b1;
        opcode = 3'd1;
        @(posedge clk); #1;
        start = 1'b0;
        lat0 = 0; lat1 = 0; lat15 = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (bus0.result_valid && lat0 == 0)   lat0 = e;
            if (bus1.result_valid && lat1 == 0)   lat1 = e;
            if (bus15.result_valid && lat15 == 0) lat15 = e;
        end
        check("latency_settle2", lat0, 32'd2);
        check("latency_settle1", lat1, 32'd1);
        check("latency_settle15", lat15, 32'd15);
        check("result_settle15", {24'd0, bus15.result}, 32'h71);
        check("result_settle1", {24'd0, bus1.result}, 32'h71);

        // Reset while in HOLD abandons the op
        rst_n = 1'b0;
        #1;
        check("reset_in_hold", {11'd0, snap0()}, 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", {23'd0, bus0.result_valid, bus0.op_count}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            start  = vecs[i].start;
            opcode = vecs[i].opcode;
            ack    = vecs[i].ack;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), {11'd0, snap0()}, {11'd0, vecs[i].exp});
        end
        start = 1'b0;
        ack   = 1'b0;

        // Bring op_count to 255, then one more op must wrap to 0
        for (int i = 0; i < 252; i++) begin
            run_op(3'(i), ok);
            if (!ok) break;
            ack_op();
        end
        check("count_255", {24'd0, bus0.op_count}, 32'd255);
        run_op(3'd6, ok);
        check("wrap_state", {11'd0, snap0()}, {11'd0, 3'd6, 8'h76, 1'b1, 1'b1, 8'd0});
        ack_op();
        check("wrap_ack_idle", {11'd0, snap0()}, {11'd0, 3'd6, 8'h76, 1'b0, 1'b0, 8'd0});

        // Asynchronous reset between edges in SETTLE
        start  = 1'b1;
        opcode = 3'd4;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_settle", {11'd0, snap0()}, 32'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("idle_after_reset%0d", i),
                  {23'd0, bus0.result_valid, bus0.op_count}, 32'd0);
        end

        // First start after reset is accepted normally
        run_op(3'd3, ok);
        check("first_op_after_reset", {11'd0, snap0()},
              {11'd0, 3'd3, 8'h73, 1'b1, 1'b1, 8'd1});
        ack_op();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/op_select_ctrl.md
OP_SELECT_CTRL -- requirements
Module: op_select_ctrl

Interface
REQ-001 Parameter SETTLE, default 2: clock cycles the mux select is held before the result is captured; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE, or in HOLD together with ack.
REQ-005 opcode  input  3  operation select captured on an accepted start.
REQ-006 mux_out  input  8  result bus returned from the downstream 8-bit 8:1 operation mux.
REQ-007 ack  input  1  consumer acknowledges result; meaningful only in HOLD.
REQ-008 sel  output  3  registered select to the mux: sel[2]->s2, sel[1]->s1, sel[0]->s0.
REQ-009 result  output  8  registered captured mux_out.
REQ-010 result_valid  output  1  high while result holds an unacknowledged value.
REQ-011 busy  output  1  high in SETTLE and HOLD.
REQ-012 op_count  output  8  number of completed captures, modulo 256.

Function
REQ-013 FSM states SHALL be exactly IDLE, SETTLE, HOLD; one-hot or binary at implementer's choice.
REQ-014 IDLE: start=1 at an edge -> sel<=opcode, settle counter<=0, state->SETTLE; start=0 -> remain IDLE, sel unchanged.
REQ-015 SETTLE: counter increments each edge; at the edge where counter==SETTLE-1 -> result<=mux_out, result_valid<=1, op_count<=op_count+1, state->HOLD.
REQ-016 Latency: result_valid SHALL rise exactly SETTLE edges after the edge that accepted start.
REQ-017 start and opcode SHALL be ignored in SETTLE; sel SHALL not change during SETTLE.
REQ-018 HOLD: result and result_valid held stable until ack=1 sampled.
REQ-019 HOLD, ack=1, start=0 -> result_valid<=0, state->IDLE; result keeps its value.
REQ-020 HOLD, ack=1, start=1 -> result_valid<=0, sel<=opcode, counter<=0, state->SETTLE (back-to-back, no IDLE cycle).
REQ-021 HOLD, ack=0, start=1 -> start ignored, remain HOLD.
REQ-022 ack in IDLE or SETTLE SHALL be ignored.
REQ-023 sel SHALL keep its last value in IDLE and HOLD (only REQ-014/REQ-020 change it).
REQ-024 op_count SHALL wrap 255 -> 0 without side effect.
REQ-025 busy SHALL be a decode of state (0 in IDLE, 1 otherwise), no extra latency.
REQ-026 mux_out is treated as combinational from sel; no sampling of mux_out outside REQ-015.

Reset
REQ-027 rst_n=0 SHALL immediately, without clock, force: state=IDLE, sel=0, result=0x00, result_valid=0, busy=0, op_count=0, settle counter=0.
REQ-028 Reset asserted mid-SETTLE or mid-HOLD SHALL abandon the operation; no result_valid pulse and no op_count increment follow.
REQ-029 After rst_n deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-030 SETTLE=2, start=1 opcode=3'b101 one cycle, mux_out modelled as 8x1 of {0x70..0x77} -> sel=5 next cycle; result_valid rises 2 edges after accept with result=0x75, op_count=1, busy=1 until ack.
REQ-031 In HOLD, ack=1 with start=1 opcode=3'b010 -> next cycle result_valid=0, sel=2, state SETTLE; after 2 more edges result=0x72, op_count=2.
REQ-032 start pulses with opcode=7 during SETTLE and during HOLD with ack=0 -> sel unchanged, result unchanged, no extra op_count increment.
REQ-033 Preload op_count=255 via 255 completed ops, run one more -> op_count=0, result_valid=1, all other behaviour normal.
REQ-034 Assert rst_n=0 asynchronously between edges in SETTLE -> outputs zero immediately; release, idle 3 cycles -> result_valid stays 0, op_count=0.
REQ-035 SETTLE=1 and SETTLE=15 builds, single op each -> result_valid rises exactly 1 and 15 edges after accept respectively.
